wfg_sequencer: RTL and testbench
================================

# wfg_sequencer

Programmable scheduler for the waveform generator (WFG).
- Stores a short program of segments, each a {function code, duration} pair.
- Drives the WFG's `func` select and `rst` inputs so the generator plays the segments back-to-back, once or looping.
- Sits between the lab control logic (switches/bench) and the WFG instance; it replaces the static `func` register and the hand-driven WFG reset.

## Interface
Parameters:
- `DEPTH`, 8, number of program entries (power of two).
- `IDX_W`, 3, log2(DEPTH).
- `DUR_W`, 16, duration counter width in clock cycles.
- `FUNC_W`, 3, WFG function-select width.

Ports:
- `clk`  in  1  system clock, same clock as the WFG.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write one program entry this cycle.
- `wr_addr`  in  IDX_W  entry index to write.
- `wr_func`  in  FUNC_W  function code for the entry.
- `wr_dur`  in  DUR_W  segment length in cycles; 0 is treated as 1.
- `last_idx`  in  IDX_W  index of the final segment; sampled on accepted `start`.
- `loop`  in  1  replay from entry 0 after `last_idx`; sampled on accepted `start`.
- `start`  in  1  begin playback (level, acted on when IDLE).
- `stop`  in  1  abort playback.
- `func`  out  FUNC_W  function select to WFG.
- `wfg_rst`  out  1  reset to WFG.
- `busy`  out  1  playback in progress.
- `done`  out  1  one-cycle pulse at normal completion.
- `seg_idx`  out  IDX_W  index of the segment currently driven.

## Operation
- All outputs are registered.
- Reset values:
  - Outputs: `func`=0, `wfg_rst`=1, `busy`=0, `done`=0, `seg_idx`=0.
  - Internal: state=IDLE.
  - Program memory: every entry is cleared to func 0, dur 0.
- Program writes:
  - Accepted only while `busy`=0.
  - Ignored while `busy`=1; the program is never modified mid-playback.
- States:
  - **IDLE**:
    - Outputs: `wfg_rst`=1, `busy`=0.
    - On `start` (and `stop`=0): latch `last_idx` and `loop`, set `seg_idx`=0, go to LOAD.
  - **LOAD** (1 cycle):
    - Outputs: `func`=mem[seg_idx].func, `wfg_rst`=1, `busy`=1.
    - Load the counter with max(dur,1), then go to RUN.
  - **RUN**:
    - Outputs: `wfg_rst`=0, `busy`=1.
    - The counter decrements every cycle.
    - On the cycle the counter equals 1:
      - If `seg_idx`≠last: `seg_idx`+1, go to LOAD.
      - If `seg_idx`=last and loop=1: `seg_idx`=0, go to LOAD.
      - Otherwise: go to DONE.
  - **DONE** (1 cycle):
    - Outputs: `done`=1, `wfg_rst`=1, `busy`=0.
    - Then go to IDLE.
- Precedence:
  - `stop` has priority over `start` and applies in any state. Next cycle: IDLE, `wfg_rst`=1, `busy`=0, no `done` pulse.
  - `rst` overrides everything.
- Other rules:
  - `func` holds its last value in IDLE/DONE.
  - `last_idx` > DEPTH-1 is impossible by width; every index is valid.
  - `seg_idx` wraps only through the `last_idx` comparison, never by overflow.

## Timing
- `start` sampled at edge t → LOAD visible after t+1.
- RUN occupies the next max(dur,1) cycles; the WFG is out of reset for exactly that many cycles per segment.
- Each segment costs max(dur,1)+1 cycles, including the LOAD reset cycle that re-phases the WFG.
- Non-loop program of segments 0..L: `done` asserts after Σ(max(dur_i,1)+1) cycles in RUN/LOAD, plus 1.
- `start` held high through DONE re-arms from IDLE on the following cycle; there is no restart directly from DONE.
- `stop` latency: 1 cycle to `wfg_rst`=1.

## Structure
- Shared package `wfg_pkg` holds:
  - `FUNC_W`.
  - The state enum {IDLE, LOAD, RUN, DONE}.
  - Named WFG function-code constants, shared with the WFG.
- Sub-module `wfg_seg_mem`: DEPTH×(FUNC_W+DUR_W) register file with a synchronous write port and an asynchronous read port, cleared on `rst`.
- The FSM and duration counter live in `wfg_sequencer`.

## Test plan
- Program entries 0:{6,4}, 1:{2,3}, `last_idx`=1, `loop`=0, `start` pulse → `func`=6 with `wfg_rst`=1 for 1 cycle, then `wfg_rst`=0 for 4 cycles; then `func`=2, 1 reset cycle + 3 run cycles; then `done`=1 for one cycle, `busy`=0.
- Same program with `loop`=1 → `seg_idx` sequence 0,1,0,1…; `done` never asserts. `stop` mid-RUN of segment 1 → next cycle `wfg_rst`=1, `busy`=0, `done`=0.
- Entry 0 with dur=0, `last_idx`=0 → exactly 1 RUN cycle, then DONE.
- `wr_en` to entry 0 during RUN → entry unchanged on replay; the same write in IDLE takes effect.
- `start` and `stop` high together in IDLE → remains IDLE, `busy`=0.
- `rst` asserted mid-RUN → next cycle all outputs at reset values and memory cleared (replay of entry 0 gives func 0, 1 run cycle).

Source files
------------

// File: rtl/wfg_pkg.sv
// Shared definitions for the waveform generator and its sequencer:
// function-select width, function codes and sequencer state encoding.
package wfg_pkg;

   localparam int FUNC_W = 3;

   // Function codes understood by the WFG's func select input.
   typedef enum logic [FUNC_W-1:0] {
      WFG_FN_OFF      = 3'd0,
      WFG_FN_SINE     = 3'd1,
      WFG_FN_SQUARE   = 3'd2,
      WFG_FN_TRIANGLE = 3'd3,
      WFG_FN_SAW_UP   = 3'd4,
      WFG_FN_SAW_DN   = 3'd5,
      WFG_FN_NOISE    = 3'd6,
      WFG_FN_DC       = 3'd7
   } wfg_func_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } seq_state_e;

endpackage

// File: rtl/wfg_sequencer_if.sv
// Control/status bundle between the lab control logic (master) and the
// WFG sequencer (slave): program write port, playback control, WFG drive.
interface wfg_sequencer_if #(
   parameter int IDX_W  = 3,
   parameter int DUR_W  = 16,
   parameter int FUNC_W = 3
);

   logic              wr_en;
   logic [IDX_W-1:0]  wr_addr;
   logic [FUNC_W-1:0] wr_func;
   logic [DUR_W-1:0]  wr_dur;
   logic [IDX_W-1:0]  last_idx;
   logic              loop;
   logic              start;
   logic              stop;

   logic [FUNC_W-1:0] func;
   logic              wfg_rst;
   logic              busy;
   logic              done;
   logic [IDX_W-1:0]  seg_idx;

   modport master (
      output wr_en, wr_addr, wr_func, wr_dur, last_idx, loop, start, stop,
      input  func, wfg_rst, busy, done, seg_idx
   );

   modport slave (
      input  wr_en, wr_addr, wr_func, wr_dur, last_idx, loop, start, stop,
      output func, wfg_rst, busy, done, seg_idx
   );

endinterface

// File: rtl/wfg_seg_mem.sv
// Segment program register file: DEPTH entries of {func, dur}, synchronous
// write, asynchronous read, cleared to all-zero on reset.
module wfg_seg_mem
   import wfg_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int IDX_W  = 3,
   parameter int DUR_W  = 16,
   parameter int FUNC_W = wfg_pkg::FUNC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [FUNC_W-1:0] wr_func,
   input  logic [DUR_W-1:0]  wr_dur,
   input  logic [IDX_W-1:0]  rd_addr,
   output logic [FUNC_W-1:0] rd_func,
   output logic [DUR_W-1:0]  rd_dur
);

   logic [FUNC_W-1:0] func_q [DEPTH];
   logic [FUNC_W-1:0] func_d [DEPTH];
   logic [DUR_W-1:0]  dur_q  [DEPTH];
   logic [DUR_W-1:0]  dur_d  [DEPTH];

   always_comb begin
      func_d = func_q;
      dur_d  = dur_q;
      if (wr_en) begin
         func_d[wr_addr] = wr_func;
         dur_d[wr_addr]  = wr_dur;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            func_q[i] <= '0;
            dur_q[i]  <= '0;
         end
      end else begin
         func_q <= func_d;
         dur_q  <= dur_d;
      end
   end

   assign rd_func = func_q[rd_addr];
   assign rd_dur  = dur_q[rd_addr];

endmodule

// File: rtl/wfg_sequencer.sv
// Plays a stored program of {func, dur} segments into the WFG, pulsing the
// WFG reset for one cycle between segments so every segment starts in phase.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | WFG held in reset, program writable, waiting for start
// ST_LOAD | func driven for seg_idx, WFG reset, duration counter loaded
// ST_RUN  | WFG running, counter counts down to terminal count 1
// ST_DONE | one-cycle done pulse after the last segment, WFG in reset
module wfg_sequencer
   import wfg_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int IDX_W  = 3,
   parameter int DUR_W  = 16,
   parameter int FUNC_W = wfg_pkg::FUNC_W
) (
   input logic            clk,
   input logic            rst,
   wfg_sequencer_if.slave sq
);

   seq_state_e        state_q, state_d;
   logic [IDX_W-1:0]  seg_idx_q, seg_idx_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic              loop_q, loop_d;
   logic [DUR_W-1:0]  cnt_q, cnt_d;
   logic [FUNC_W-1:0] func_q, func_d;
   logic              wfg_rst_q, wfg_rst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [FUNC_W-1:0] rd_func;
   logic [DUR_W-1:0]  rd_dur;
   logic              cnt_tc;

   // The program is frozen while busy so a replay always sees what was started.
   wfg_seg_mem #(
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W),
      .DUR_W  (DUR_W),
      .FUNC_W (FUNC_W)
   ) u_seg_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (sq.wr_en & ~busy_q),
      .wr_addr (sq.wr_addr),
      .wr_func (sq.wr_func),
      .wr_dur  (sq.wr_dur),
      .rd_addr (seg_idx_d),
      .rd_func (rd_func),
      .rd_dur  (rd_dur)
   );

   assign cnt_tc = (cnt_q == DUR_W'(1));

   always_comb begin
      state_d   = state_q;
      seg_idx_d = seg_idx_q;
      last_d    = last_q;
      loop_d    = loop_q;
      if (sq.stop) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sq.start) begin
                  state_d   = ST_LOAD;
                  seg_idx_d = '0;
                  last_d    = sq.last_idx;
                  loop_d    = sq.loop;
               end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
               if (cnt_tc) begin
                  if (seg_idx_q != last_q) begin
                     seg_idx_d = seg_idx_q + IDX_W'(1);
                     state_d   = ST_LOAD;
                  end else if (loop_q) begin
                     seg_idx_d = '0;
                     state_d   = ST_LOAD;
                  end else begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they register alongside it.
   // The memory read address is seg_idx_d, so rd_* already holds the entry
   // being entered (LOAD entry) or the one being loaded (in LOAD).
   always_comb begin
      func_d    = func_q;
      cnt_d     = cnt_q;
      wfg_rst_d = (state_d != ST_RUN);
      busy_d    = (state_d == ST_LOAD) || (state_d == ST_RUN);
      done_d    = (state_d == ST_DONE);
      if (state_d == ST_LOAD) begin
         func_d = rd_func;
      end
      if (state_q == ST_LOAD) begin
         cnt_d = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
      end else if (state_q == ST_RUN) begin
         cnt_d = cnt_q - DUR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         seg_idx_q <= '0;
         last_q    <= '0;
         loop_q    <= 1'b0;
         cnt_q     <= '0;
         func_q    <= '0;
         wfg_rst_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         seg_idx_q <= seg_idx_d;
         last_q    <= last_d;
         loop_q    <= loop_d;
         cnt_q     <= cnt_d;
         func_q    <= func_d;
         wfg_rst_q <= wfg_rst_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign sq.func    = func_q;
   assign sq.wfg_rst = wfg_rst_q;
   assign sq.busy    = busy_q;
   assign sq.done    = done_q;
   assign sq.seg_idx = seg_idx_q;

endmodule

// File: tb/tb_wfg_sequencer.sv
// Self-checking bench for wfg_sequencer: expected output frames are expanded
// from the program contents, then compared cycle by cycle against the DUT.
module tb_wfg_sequencer;
   import wfg_pkg::*;

   localparam int DEPTH = 8;
   localparam int IDX_W = 3;
   localparam int DUR_W = 16;
   localparam int FW    = FUNC_W;

   typedef logic [FW+IDX_W+2:0] frame_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wfg_sequencer_if #(.IDX_W(IDX_W), .DUR_W(DUR_W), .FUNC_W(FW)) sq ();

   wfg_sequencer #(
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W),
      .DUR_W  (DUR_W),
      .FUNC_W (FW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sq  (sq)
   );

   int n_checks = 0;
   int n_errors = 0;
   int unsigned m_func [DEPTH];
   int unsigned m_dur  [DEPTH];
   frame_t trace [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic frame_t mk(int unsigned f, bit r, bit b, bit d, int unsigned i);
      return {FW'(f), r, b, d, IDX_W'(i)};
   endfunction

   function automatic frame_t obs();
      return {sq.func, sq.wfg_rst, sq.busy, sq.done, sq.seg_idx};
   endfunction

   // Same func/seg_idx as f, WFG in reset, not busy, no done.
   function automatic frame_t idle_of(frame_t f);
      frame_t r = f;
      r[IDX_W+2] = 1'b1;
      r[IDX_W+1] = 1'b0;
      r[IDX_W]   = 1'b0;
      return r;
   endfunction

   function automatic void clear_model();
      for (int i = 0; i < DEPTH; i++) begin
         m_func[i] = 0;
         m_dur[i]  = 0;
      end
   endfunction

   // Expand the program into per-cycle output frames, starting with the
   // frame visible right after the start edge.
   function automatic void build_trace(bit lp, int unsigned last, int len);
      int unsigned i = 0;
      trace.delete();
      while (trace.size() < len) begin
         trace.push_back(mk(m_func[i], 1, 1, 0, i));
         for (int unsigned k = 0; k < ((m_dur[i] == 0) ? 1 : m_dur[i]); k++)
            trace.push_back(mk(m_func[i], 0, 1, 0, i));
         if (i == last) begin
            if (lp) i = 0;
            else begin
               trace.push_back(mk(m_func[i], 1, 0, 1, i));
               while (trace.size() < len) trace.push_back(mk(m_func[i], 1, 0, 0, i));
            end
         end else begin
            i++;
         end
      end
   endfunction

   task automatic write_entry(input int unsigned a, input int unsigned f, input int unsigned d);
      sq.wr_en   = 1'b1;
      sq.wr_addr = IDX_W'(a);
      sq.wr_func = FW'(f);
      sq.wr_dur  = DUR_W'(d);
      @(posedge clk); #1;
      sq.wr_en = 1'b0;
      m_func[a] = f;
      m_dur[a]  = d;
      chk("wr_idle_busy", 32'(sq.busy), 32'(0));
   endtask

   // abort_at < 0: no abort. Otherwise stop (or rst) is applied at that edge.
   task automatic run(input string tag, input bit lp, input int unsigned last, input int len,
                      input int abort_at, input bit abort_rst, input bit wr_noise);
      build_trace(lp, last, len);
      sq.last_idx = IDX_W'(last);
      sq.loop     = lp;
      sq.start    = 1'b1;
      for (int c = 0; c < len; c++) begin
         if (c == abort_at) begin
            if (abort_rst) rst = 1'b1;
            else sq.stop = 1'b1;
         end
         if (wr_noise && c > 0 && trace[c-1][IDX_W+1] && $urandom_range(0, 1) == 0) begin
            sq.wr_en   = 1'b1;
            sq.wr_addr = IDX_W'($urandom);
            sq.wr_func = FW'($urandom);
            sq.wr_dur  = DUR_W'($urandom_range(0, 5));
         end
         @(posedge clk); #1;
         sq.start = 1'b0;
         sq.wr_en = 1'b0;
         if (c == abort_at) begin
            rst     = 1'b0;
            sq.stop = 1'b0;
            if (abort_rst) begin
               clear_model();
               chk({tag, "_rst"}, 32'(obs()), 32'(mk(0, 1, 0, 0, 0)));
            end else begin
               chk({tag, "_stop"}, 32'(obs()), 32'(idle_of(trace[c-1])));
            end
            return;
         end
         chk(tag, 32'(obs()), 32'(trace[c]));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      sq.wr_en    = 1'b0;
      sq.wr_addr  = '0;
      sq.wr_func  = '0;
      sq.wr_dur   = '0;
      sq.last_idx = '0;
      sq.loop     = 1'b0;
      sq.start    = 1'b0;
      sq.stop     = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_frame", 32'(obs()), 32'(mk(0, 1, 0, 0, 0)));
      rst = 1'b0;

      run("cleared_prog", 0, 0, 5, -1, 0, 0);

      write_entry(0, 6, 4);
      write_entry(1, 2, 3);
      run("two_seg", 0, 1, 14, -1, 0, 0);

      // stop lands while segment 1 is running in the second pass
      run("loop", 1, 1, 20, 17, 0, 0);

      write_entry(0, 5, 0);
      run("dur0", 0, 0, 6, -1, 0, 0);

      write_entry(0, 6, 4);
      run("wr_in_run", 0, 1, 14, -1, 0, 1);
      run("replay", 0, 1, 14, -1, 0, 0);
      write_entry(0, 3, 2);
      run("wr_idle_replay", 0, 1, 12, -1, 0, 0);

      sq.start = 1'b1;
      sq.stop  = 1'b1;
      @(posedge clk); #1;
      sq.start = 1'b0;
      sq.stop  = 1'b0;
      chk("start_stop_busy", 32'(sq.busy), 32'(0));
      chk("start_stop_rst", 32'(sq.wfg_rst), 32'(1));
      @(posedge clk); #1;
      chk("start_stop_hold", 32'(sq.busy), 32'(0));

      run("rst_mid_run", 0, 1, 12, 3, 1, 0);
      run("after_rst", 0, 1, 8, -1, 0, 0);

      for (int it = 0; it < 30; it++) begin
         int unsigned nw = $urandom_range(1, 6);
         bit lp = ($urandom_range(0, 2) == 0);
         int unsigned last = $urandom_range(0, DEPTH - 1);
         int ab = -1;
         bit ab_rst = 1'b0;
         for (int k = 0; k < nw; k++)
            write_entry($urandom_range(0, DEPTH - 1), $urandom_range(0, 7), $urandom_range(0, 6));
         if (lp || $urandom_range(0, 3) == 0) begin
            ab = $urandom_range(1, 60);
            ab_rst = ($urandom_range(0, 5) == 0);
         end
         run("rand", lp, last, 64, ab, ab_rst, $urandom_range(0, 1) == 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
